// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receive and transmit byte FIFOs.
package uart_pkg;

    localparam int UART_DATA_WIDTH = 8;

    // Width of a fill-level counter able to hold every value from 0 to depth.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Byte-in / valid-ready byte-out bundle between the UART receiver, the FIFO and its consumer.
interface uart_rx_fifo_if #(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = uart_pkg::UART_DATA_WIDTH
);

    logic [DATA_WIDTH-1:0]                     in_data;
    logic                                      in_strobe;
    logic [DATA_WIDTH-1:0]                     out_data;
    logic                                      out_valid;
    logic                                      out_ready;
    logic [uart_pkg::level_width(DEPTH)-1:0]   level;
    logic                                      full;
    logic                                      overrun;
    logic                                      overrun_clear;

    modport master (
        output in_data, in_strobe, out_ready, overrun_clear,
        input  out_data, out_valid, level, full, overrun
    );

    modport slave (
        input  in_data, in_strobe, out_ready, overrun_clear,
        output out_data, out_valid, level, full, overrun
    );

endinterface

// File: rtl/uart_rx_fifo_ram.sv
// Byte store: one synchronous write port, one asynchronous read port, no reset.
module fifo_ram #(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_WIDTH-1:0]    rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write port; contents are deliberately left unreset so this maps to distributed RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side show-ahead byte FIFO with fill level and sticky overrun flag.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
    input logic           clk,
    input logic           rst_n,
    uart_rx_fifo_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = level_width(DEPTH);
    localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);

    if (!is_pow2(DEPTH)) begin : g_depth_check
        $error("uart_rx_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [AW-1:0]         wp_r;
    logic [AW-1:0]         rp_r;
    logic [LW-1:0]         level_r;
    logic                  overrun_r;
    logic                  full_s;
    logic                  valid_s;
    logic                  pop_s;
    logic                  push_s;
    logic                  drop_s;
    logic [DATA_WIDTH-1:0] rd_data_s;

    assign full_s  = (level_r == LEVEL_FULL);
    assign valid_s = (level_r != {LW{1'b0}});
    assign pop_s   = valid_s & bus.out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push_s  = bus.in_strobe & (~full_s | pop_s);
    assign drop_s  = bus.in_strobe & full_s & ~pop_s;

    fifo_ram #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (push_s),
        .waddr (wp_r),
        .wdata (bus.in_data),
        .raddr (rp_r),
        .rdata (rd_data_s)
    );

    // Pointer and fill-level bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_r    <= {AW{1'b0}};
            rp_r    <= {AW{1'b0}};
            level_r <= {LW{1'b0}};
        end else begin
            if (push_s) begin
                wp_r <= wp_r + AW'(1'b1);
            end else begin
                wp_r <= wp_r;
            end
            if (pop_s) begin
                rp_r <= rp_r + AW'(1'b1);
            end else begin
                rp_r <= rp_r;
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LW'(1'b1);
                2'b01:   level_r <= level_r - LW'(1'b1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Sticky overrun flag; a drop in the clearing cycle keeps it set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_r <= 1'b0;
        end else if (drop_s) begin
            overrun_r <= 1'b1;
        end else if (bus.overrun_clear) begin
            overrun_r <= 1'b0;
        end else begin
            overrun_r <= overrun_r;
        end
    end

    assign bus.out_valid = valid_s;
    assign bus.out_data  = valid_s ? rd_data_s : {DATA_WIDTH{1'b0}};
    assign bus.level     = level_r;
    assign bus.full      = full_s;
    assign bus.overrun   = overrun_r;

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer that sits directly downstream of the UART receiver. It captures each byte presented with a one-cycle `received`-style strobe into a circular store. It presents bytes in arrival order on a valid/ready output toward the consuming logic (command parser, LED/debug sinks). It also reports fill level and records overruns, so that a slow consumer never corrupts the receiver.

## Interface
- `DEPTH`, 16: number of byte slots; power of two, ≥2.
- `DATA_WIDTH`, 8: byte width; matches the receiver's data output.

- `clk`, in, 1: single clock for all logic.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `in_data`, in, DATA_WIDTH: received byte; sampled only when `in_strobe`=1.
- `in_strobe`, in, 1: one-cycle write pulse (receiver's `received`).
- `out_data`, out, DATA_WIDTH: oldest stored byte; forced to 0 while `out_valid`=0.
- `out_valid`, out, 1: FIFO non-empty.
- `out_ready`, in, 1: consumer accepts; a pop occurs when `out_valid`&&`out_ready` at a rising edge.
- `level`, out, $clog2(DEPTH)+1: number of stored bytes, 0..DEPTH.
- `full`, out, 1: `level`==DEPTH.
- `overrun`, out, 1: sticky; set when a byte was dropped.
- `overrun_clear`, in, 1: synchronous clear of `overrun`.

## Operation
- Storage: DEPTH×DATA_WIDTH array, write pointer `wp`, read pointer `rp`, each $clog2(DEPTH) bits. Pointers wrap modulo DEPTH by natural overflow. `level` is a separate counter.
- Push: `in_strobe`=1 and (`full`=0 or pop in same cycle). Write `mem[wp]`<=`in_data` and increment `wp`.
- Pop: `out_valid`=1 and `out_ready`=1. Increment `rp`.
- `level` update: push only +1; pop only −1; push and pop together unchanged.
- Full and `in_strobe` without pop: byte dropped, no pointer or level change, `overrun`<=1.
- Full and `in_strobe` with pop: both happen; `level` stays DEPTH; no overrun.
- Empty and `in_strobe` with `out_ready`=1: no pop, because `out_valid` is 0; the push happens.
- `overrun_clear` and a new drop in the same cycle: set wins and `overrun` stays 1.
- `out_ready` while empty is ignored.
- No state machine beyond the pointers and counter. Show-ahead (first-word-fall-through): `out_data`=`mem[rp]` gated by `out_valid`.
- Reset (asynchronous, any time, including mid-burst): `wp`=`rp`=0, `level`=0, `out_valid`=0, `out_data`=0, `full`=0, `overrun`=0. Array contents are not reset and are unobservable.

## Timing
- Write latency: `in_strobe` sampled at edge N → `out_valid`=1 and `out_data` valid from just after edge N (cycle N+1) when previously empty.
- Pop: `out_ready` at edge M → next byte (or `out_valid`=0) visible from cycle M+1. The consumer can sustain one byte per cycle.
- `level`, `full`, `overrun` are registered and update on the same edge as the causing push/pop/drop.
- `out_data`, `out_valid`, `full` derive combinationally from registered state only. There is no combinational path from `out_ready` or `in_strobe` to any output.
- The input side has no backpressure; the receiver never stalls.

## Structure
- Shared package/header `uart_pkg`: `UART_DATA_WIDTH`=8 and the `level` width function $clog2(DEPTH)+1, shared with the transmit-side FIFO.
- One sub-module `fifo_ram`: DEPTH×DATA_WIDTH, one synchronous write port and one asynchronous read port, no reset. It maps to distributed RAM on iCE40/ECP5.
- Top level holds pointers, level counter, overrun flag, and output gating.
- Parameter check: elaboration error if DEPTH is not a power of two or is <2.

## Test plan
- Reset/idle: assert `rst_n`=0 mid-simulation with 3 bytes stored → next cycle `level`=0, `out_valid`=0, `out_data`=0, `overrun`=0.
- Order: strobe 0x41, 0x42, 0x43 with `out_ready`=0 → `level`=3, `out_data`=0x41. Then `out_ready`=1 for 3 cycles → 0x41, 0x42, 0x43 observed, then `out_valid`=0.
- Fill/overrun (DEPTH=16): 17 strobes of 0x00..0x10, no reads → `full`=1, `level`=16, `overrun`=1. Drain yields 0x00..0x0F only. `overrun_clear` → `overrun`=0.
- Full with simultaneous push and pop: full FIFO, strobe 0x99 with `out_ready`=1 → `level` stays 16, `overrun`=0, 0x99 emerges 16th.
- Wrap-around: 40 bytes pushed and popped at random gaps with `level` never above 5 → output sequence equals input sequence and pointers cross 0 twice.
- Clear vs. set: `overrun_clear`=1 in the same cycle as a dropped strobe → `overrun`=1 afterwards.
